top: RTL and testbench
======================

# top

Top-level single-motor timer controller for the board build. Debounces three push-buttons, runs a four-state controller (IDLE/SET/RUN/PAUSE), and drives a two-wire H-bridge direction pair from two slide switches. Shows the state code and a 0–99 s countdown on a multiplexed 4-digit seven-segment display. Sits directly under the board pin map and needs no other RTL.

## Interface
- CLK_HZ, 100_000_000 — clock frequency; one second equals CLK_HZ cycles.
- DB_CYCLES, 1_000_000 — number of cycles a synchronized button level must stay stable to be accepted.
- SCAN_CYCLES, 100_000 — display dwell time per digit.
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-low reset.
- motor_direction  in  2  direction switches {sw3, sw2}; asynchronous input, double-flop synchronized.
- BTNC  in  1  push-button: start/cancel.
- BTNU  in  1  push-button: increment setpoint.
- BTND  in  1  push-button: run/pause/resume.
- o_run  out  1  high only while in RUN.
- o_state  out  4  one-hot state code: IDLE=0001, SET=0010, RUN=0100, PAUSE=1000.
- in1_in2  out  2  H-bridge inputs {IN1, IN2}.
- fnd_data  out  8  segment pattern {dp,g,f,e,d,c,b,a}, active-low.
- fnd_com  out  4  digit enables, active-low, one-hot; bit0 is the rightmost digit.

## Operation
- **Button path (per button).** 2-flop synchronizer, then a debounce counter. The debounced level changes only after the synchronized level has been stable for DB_CYCLES. Each debounced rising edge produces a one-cycle press pulse. Holding a button gives exactly one pulse. Releasing a button gives no pulse.
- **Press priority.** If press pulses coincide in the same cycle: BTNC > BTND > BTNU. Only the highest-priority press is acted on.
- **Registers.** setpoint (7 bits, 0–99), remaining (7 bits), and a seconds prescaler counting 0..CLK_HZ-1.
- **IDLE:**
  - BTNC → SET; setpoint and remaining cleared.
  - BTNU and BTND are ignored.
- **SET:**
  - BTNU → setpoint+1, saturating at 99.
  - BTND with setpoint>0 → RUN; remaining loaded with setpoint, prescaler cleared.
  - BTND with setpoint=0 is ignored.
  - BTNC → IDLE.
- **RUN:**
  - The prescaler advances every cycle. At CLK_HZ-1 it wraps and remaining decrements.
  - When remaining goes 1→0, the state goes to IDLE in that same cycle.
  - BTND → PAUSE.
  - BTNC → IDLE.
  - BTNU is ignored.
- **PAUSE:**
  - The prescaler and remaining are frozen.
  - BTND → RUN; counting resumes from the frozen prescaler value.
  - BTNC → IDLE.
  - BTNU is ignored.
- **Motor drive.** in1_in2 is 00 in every state other than RUN. In RUN it is set from the synchronized switches:
  - motor_direction 01 → in1_in2 01 (forward).
  - motor_direction 10 → in1_in2 10 (reverse).
  - motor_direction 00 or 11 → in1_in2 00 (never 11).
  - A direction change mid-run takes effect without leaving RUN.
- **Display.** A ring counter steps fnd_com through 1110→1101→1011→0111→1110, advancing every SCAN_CYCLES.
  - Digit3 shows the state index: IDLE 0, SET 1, RUN 2, PAUSE 3.
  - Digit2 is blank (FF).
  - Digits1:0 show a decimal value: 00 in IDLE, setpoint in SET, remaining in RUN and PAUSE.
  - Digit patterns: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. dp is always off.

## Timing
- **Reset values:** o_state=0001, o_run=0, in1_in2=00, fnd_com=1110, fnd_data=C0. setpoint, remaining, prescaler and scan counter are all 0. Debounced levels are 0.
- **Reset mid-operation:** immediate return to IDLE with motor off, regardless of state.
- **Press latency:** 2 sync cycles + DB_CYCLES + 1 cycle from the pin edge to the pulse. The state register updates on the cycle after the pulse.
- **State-derived outputs:** o_state, o_run and in1_in2 are registered and change on the same edge as the state register.
- **Switch change in RUN:** reaches in1_in2 within 3 cycles.
- **RUN duration:** with no pause, setpoint×CLK_HZ cycles from RUN entry to IDLE. Pauses add their length exactly, with no lost or gained cycles.
- **Display:** fnd_data is registered and aligned with fnd_com on the same edge. A value change is visible no later than the next time its digit is scanned.

## Test plan
- Parameters for all scenarios: CLK_HZ=1000, DB_CYCLES=10, SCAN_CYCLES=4.
- Reset low, then high → o_state=0001, o_run=0, in1_in2=00, fnd_com=1110, fnd_data=C0.
- BTNC held 30 cycles, then BTNU pressed 3 times → SET(0010); scanned digits read C0 (digit1), B0 (digit0), F9 (digit3). A 5-cycle BTNU glitch produces no increment.
- From setpoint 3 with motor_direction=01, press BTND → RUN(0100), o_run=1, in1_in2=01. Remaining goes 3→2→1 at 1000-cycle steps. IDLE and in1_in2=00 occur exactly 3000 cycles after RUN entry.
- RUN with setpoint 5, BTND at 1500 cycles → PAUSE(1000), in1_in2=00, remaining stays 4 for 2000 cycles. BTND again → RUN; IDLE occurs after 3500 more run cycles.
- In RUN, motor_direction 01→10→11 → in1_in2 01→10→00 with no state change. BTNC and BTND pressed in the same cycle → IDLE.
- SET with BTNU pressed 101 times → display 99. Reset asserted in RUN → outputs return to reset values immediately.

Source files
------------

// File: rtl/top.sv
// Single-motor timer controller: debounced buttons, IDLE/SET/RUN/PAUSE control,
// H-bridge direction drive and a multiplexed 4-digit seven-segment display.
module top #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned DB_CYCLES   = 1_000_000,
  parameter int unsigned SCAN_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] motor_direction,
  input  logic       BTNC,
  input  logic       BTNU,
  input  logic       BTND,
  output logic       o_run,
  output logic [3:0] o_state,
  output logic [1:0] in1_in2,
  output logic [7:0] fnd_data,
  output logic [3:0] fnd_com
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned DW = $clog2(DB_CYCLES + 1);
  localparam int unsigned SW = $clog2(SCAN_CYCLES + 1);
  localparam int unsigned VW = 7;
  localparam logic [VW-1:0] SET_MAX = VW'(99);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_SET   = 4'b0010,
    S_RUN   = 4'b0100,
    S_PAUSE = 4'b1000
  } state_t;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // Button index: 0 = BTNC, 1 = BTNU, 2 = BTND
  logic [2:0]    btn_s1, btn_s2, db, db_q, press;
  logic [DW-1:0] db_cnt [3];
  logic [1:0]    sw_s1, sw_s2;

  // Synchronize, debounce and edge-detect the buttons; synchronize the switches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      db     <= '0;
      db_q   <= '0;
      press  <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      btn_s1 <= {BTND, BTNU, BTNC};
      btn_s2 <= btn_s1;
      db_q   <= db;
      press  <= db & ~db_q;
      sw_s1  <= motor_direction;
      sw_s2  <= sw_s1;
      for (int i = 0; i < 3; i++) begin
        if (btn_s2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DB_CYCLES - 1)) begin
          db[i]     <= btn_s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  logic p_c, p_d, p_u;
  assign p_c = press[0];
  assign p_d = press[2] & ~press[0];
  assign p_u = press[1] & ~press[0] & ~press[2];

  state_t        state, state_nxt;
  logic [VW-1:0] setpoint, setpoint_nxt, remaining, remaining_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic          tick;
  logic          run_nxt;
  logic [1:0]    drive_nxt;

  // State, datapath and state-derived output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      setpoint  <= '0;
      remaining <= '0;
      presc     <= '0;
      o_run     <= 1'b0;
      in1_in2   <= 2'b00;
    end else begin
      state     <= state_nxt;
      setpoint  <= setpoint_nxt;
      remaining <= remaining_nxt;
      presc     <= presc_nxt;
      o_run     <= run_nxt;
      in1_in2   <= drive_nxt;
    end
  end

  assign o_state = state;

  // Next-state and datapath update
  always_comb begin
    state_nxt     = state;
    setpoint_nxt  = setpoint;
    remaining_nxt = remaining;
    presc_nxt     = presc;
    tick          = (presc == PW'(CLK_HZ - 1));
    case (state)
      S_IDLE: begin
        if (p_c) begin
          state_nxt     = S_SET;
          setpoint_nxt  = '0;
          remaining_nxt = '0;
        end
      end
      S_SET: begin
        if (p_c) begin
          state_nxt = S_IDLE;
        end else if (p_d && setpoint != '0) begin
          state_nxt     = S_RUN;
          remaining_nxt = setpoint;
          presc_nxt     = '0;
        end else if (p_u && setpoint != SET_MAX) begin
          setpoint_nxt = setpoint + VW'(1);
        end
      end
      S_RUN: begin
        presc_nxt = tick ? '0 : presc + PW'(1);
        if (tick && remaining != '0) remaining_nxt = remaining - VW'(1);
        if (p_c) begin
          state_nxt = S_IDLE;
        end else if (tick && remaining == VW'(1)) begin
          state_nxt = S_IDLE;
        end else if (p_d) begin
          state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (p_c) begin
          state_nxt = S_IDLE;
        end else if (p_d) begin
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs follow the next state so they land on the same edge as the state
  always_comb begin
    run_nxt   = (state_nxt == S_RUN);
    drive_nxt = 2'b00;
    if (run_nxt) begin
      case (sw_s2)
        2'b01:   drive_nxt = 2'b01;
        2'b10:   drive_nxt = 2'b10;
        default: drive_nxt = 2'b00;
      endcase
    end
  end

  logic [SW-1:0] scan_cnt;
  logic          scan_adv;
  logic [3:0]    ring_nxt;
  logic [VW-1:0] disp_val;
  logic [1:0]    state_idx;
  logic [3:0]    ones, tens;
  logic [7:0]    seg_nxt;

  // Digit scan and segment selection for the digit about to be enabled
  always_comb begin
    disp_val  = '0;
    state_idx = 2'd0;
    case (state)
      S_SET:   begin disp_val = setpoint;  state_idx = 2'd1; end
      S_RUN:   begin disp_val = remaining; state_idx = 2'd2; end
      S_PAUSE: begin disp_val = remaining; state_idx = 2'd3; end
      default: begin disp_val = '0;        state_idx = 2'd0; end
    endcase
    ones     = 4'(disp_val % VW'(10));
    tens     = 4'(disp_val / VW'(10));
    scan_adv = (scan_cnt == SW'(SCAN_CYCLES - 1));
    ring_nxt = scan_adv ? {fnd_com[2:0], fnd_com[3]} : fnd_com;
    case (ring_nxt)
      4'b1110: seg_nxt = seg7(ones);
      4'b1101: seg_nxt = seg7(tens);
      4'b0111: seg_nxt = seg7({2'b00, state_idx});
      default: seg_nxt = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      fnd_com  <= 4'b1110;
      fnd_data <= 8'hC0;
    end else begin
      scan_cnt <= scan_adv ? '0 : scan_cnt + SW'(1);
      fnd_com  <= ring_nxt;
      fnd_data <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_top.sv
// Bench for the timer controller: scoreboard of expected state-output transitions
// plus directed display and reset checks.
module tb_top;

  localparam int unsigned CLK_HZ = 1000;
  localparam int unsigned DB     = 10;
  localparam int unsigned SCAN   = 4;
  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_SET   = 4'b0010;
  localparam logic [3:0] ST_RUN   = 4'b0100;
  localparam logic [3:0] ST_PAUSE = 4'b1000;
  localparam int LAT = 14;  // pin edge to state change: 2 + DB + 1 + 1

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] motor_direction = 2'b01;
  logic       BTNC = 1'b0, BTNU = 1'b0, BTND = 1'b0;
  logic       o_run;
  logic [3:0] o_state;
  logic [1:0] in1_in2;
  logic [7:0] fnd_data;
  logic [3:0] fnd_com;

  top #(.CLK_HZ(CLK_HZ), .DB_CYCLES(DB), .SCAN_CYCLES(SCAN)) dut (
    .clk(clk), .reset(reset), .motor_direction(motor_direction),
    .BTNC(BTNC), .BTNU(BTNU), .BTND(BTND),
    .o_run(o_run), .o_state(o_state), .in1_in2(in1_in2),
    .fnd_data(fnd_data), .fnd_com(fnd_com)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [6:0] val;
    int         cyc;
  } exp_t;
  exp_t sb[$];
  logic mon_en = 1'b0;
  logic [6:0] cur;
  assign cur = {o_state, o_run, in1_in2};

  function automatic logic [6:0] st(input logic [3:0] s, input logic r, input logic [1:0] d);
    return {s, r, d};
  endfunction

  task automatic push(input logic [6:0] v, input int c);
    exp_t e;
    e.val = v;
    e.cyc = c;
    sb.push_back(e);
  endtask

  // Monitor: every change of {o_state,o_run,in1_in2} must match the next expected entry
  initial begin
    logic [6:0] last;
    exp_t e;
    last = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        last = cur;
      end else if (cur !== last) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_transition: got %b from %b at cycle %0d, required no change", cur, last, cyc);
        end else begin
          e = sb.pop_front();
          if (cur !== e.val) begin
            n_fail++;
            $display("FAIL state_outputs: got %b, required %b at cycle %0d", cur, e.val, cyc);
          end
          if (e.cyc >= 0) begin
            n_chk++;
            if (cyc != e.cyc) begin
              n_fail++;
              $display("FAIL transition_cycle: got cycle %0d, required cycle %0d (value %b)", cyc, e.cyc, e.val);
            end
          end
        end
        last = cur;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic until_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       BTNC = v;
      1:       BTNU = v;
      default: BTND = v;
    endcase
  endtask

  task automatic press(input int b, input int hold);
    set_btn(b, 1'b1);
    cycles(hold);
    set_btn(b, 1'b0);
    cycles(20);
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, input string name);
    int k = 0;
    while (o_state !== s && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(o_state), 32'(s));
  endtask

  task automatic check_digit(input int idx, input logic [7:0] exp, input string name);
    logic [3:0] want;
    int k = 0;
    want = ~(4'b0001 << idx);
    while (fnd_com !== want && k < 8 * SCAN) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_com"}, 32'(fnd_com), 32'(want));
    chk(name, 32'(fnd_data), 32'(exp));
  endtask

  // Press BTND from SET; entry edge must sit exactly LAT cycles after the pin rise
  task automatic enter_run(input logic [1:0] d, output int rc);
    push(st(ST_RUN, 1'b1, d), cyc + LAT);
    set_btn(2, 1'b1);
    wait_state(ST_RUN, 40, "run_entry");
    rc = cyc;
    cycles(6);
    set_btn(2, 1'b0);
    cycles(20);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int run_cyc, pause_cyc, resume_cyc, n;

    cycles(3);
    chk("rst_state", 32'(o_state), 32'(ST_IDLE));
    chk("rst_run", 32'(o_run), 32'd0);
    chk("rst_drive", 32'(in1_in2), 32'd0);
    chk("rst_com", 32'(fnd_com), 32'hE);
    chk("rst_data", 32'(fnd_data), 32'hC0);
    reset = 1'b1;
    cycles(2);
    mon_en = 1'b1;
    cycles(1);

    // IDLE ignores BTNU and BTND
    press(1, 16);
    press(2, 16);
    chk("idle_ignore", 32'(o_state), 32'(ST_IDLE));

    // SET, setpoint 3
    push(st(ST_SET, 1'b0, 2'b00), -1);
    press(0, 30);
    repeat (3) press(1, 16);
    chk("set_state", 32'(o_state), 32'(ST_SET));
    check_digit(1, 8'hC0, "set_d1");
    check_digit(0, 8'hB0, "set_d0");
    check_digit(3, 8'hF9, "set_d3");
    check_digit(2, 8'hFF, "set_d2");
    BTNU = 1'b1;
    cycles(5);
    BTNU = 1'b0;
    cycles(30);
    check_digit(0, 8'hB0, "glitch_d0");

    // RUN for 3 s
    enter_run(2'b01, run_cyc);
    push(st(ST_IDLE, 1'b0, 2'b00), run_cyc + 3000);
    chk("run_o_run", 32'(o_run), 32'd1);
    chk("run_drive", 32'(in1_in2), 32'd1);
    check_digit(3, 8'hA4, "run_d3");
    until_cyc(run_cyc + 500);
    check_digit(0, 8'hB0, "run_rem3");
    until_cyc(run_cyc + 1500);
    check_digit(0, 8'hA4, "run_rem2");
    until_cyc(run_cyc + 2500);
    check_digit(0, 8'hF9, "run_rem1");
    until_cyc(run_cyc + 3010);
    chk("run_done", 32'(o_state), 32'(ST_IDLE));
    check_digit(0, 8'hC0, "idle_d0");

    // SET with setpoint 0 ignores BTND, then setpoint 5, RUN, PAUSE, resume
    push(st(ST_SET, 1'b0, 2'b00), -1);
    press(0, 30);
    press(2, 16);
    chk("set_zero_ignore", 32'(o_state), 32'(ST_SET));
    repeat (5) press(1, 16);
    enter_run(2'b01, run_cyc);
    push(st(ST_PAUSE, 1'b0, 2'b00), run_cyc + 1500);
    until_cyc(run_cyc + 1500 - LAT);
    set_btn(2, 1'b1);
    wait_state(ST_PAUSE, 40, "pause_entry");
    pause_cyc = cyc;
    cycles(6);
    set_btn(2, 1'b0);
    chk("pause_drive", 32'(in1_in2), 32'd0);
    check_digit(0, 8'h99, "pause_rem4");
    check_digit(3, 8'hB0, "pause_d3");
    until_cyc(pause_cyc + 2000);
    check_digit(0, 8'h99, "pause_hold4");
    chk("pause_held", 32'(o_state), 32'(ST_PAUSE));
    push(st(ST_RUN, 1'b1, 2'b01), -1);
    set_btn(2, 1'b1);
    wait_state(ST_RUN, 40, "resume_entry");
    resume_cyc = cyc;
    push(st(ST_IDLE, 1'b0, 2'b00), resume_cyc + 3500);
    cycles(6);
    set_btn(2, 1'b0);
    until_cyc(resume_cyc + 3510);
    chk("resume_done", 32'(o_state), 32'(ST_IDLE));

    // Direction changes in RUN, then BTNC+BTND together
    push(st(ST_SET, 1'b0, 2'b00), -1);
    press(0, 30);
    repeat (2) press(1, 16);
    enter_run(2'b01, run_cyc);
    push(st(ST_RUN, 1'b1, 2'b10), cyc + 3);
    motor_direction = 2'b10;
    cycles(10);
    push(st(ST_RUN, 1'b1, 2'b00), cyc + 3);
    motor_direction = 2'b11;
    cycles(10);
    chk("dir_still_run", 32'(o_state), 32'(ST_RUN));
    push(st(ST_IDLE, 1'b0, 2'b00), cyc + LAT);
    BTNC = 1'b1;
    BTND = 1'b1;
    cycles(20);
    BTNC = 1'b0;
    BTND = 1'b0;
    cycles(20);
    chk("both_to_idle", 32'(o_state), 32'(ST_IDLE));

    // Setpoint saturation at 99, then reset mid-RUN
    motor_direction = 2'b01;
    push(st(ST_SET, 1'b0, 2'b00), -1);
    press(0, 30);
    for (int i = 0; i < 101; i++) press(1, 16);
    check_digit(1, 8'h90, "sat_d1");
    check_digit(0, 8'h90, "sat_d0");
    enter_run(2'b01, run_cyc);
    cycles(50);
    push(st(ST_IDLE, 1'b0, 2'b00), -1);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_rst_state", 32'(o_state), 32'(ST_IDLE));
    chk("mid_rst_run", 32'(o_run), 32'd0);
    chk("mid_rst_drive", 32'(in1_in2), 32'd0);
    chk("mid_rst_com", 32'(fnd_com), 32'hE);
    chk("mid_rst_data", 32'(fnd_data), 32'hC0);
    @(negedge clk);
    reset = 1'b1;
    cycles(20);

    n = sb.size();
    chk("scoreboard_drained", 32'(n), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
